rv32im_alu_decode_stage: RTL and testbench

//   Decode stage feeding the RV32IM ALU: decodes one 32-bit instruction per accepted beat into the ALU SELECT code,

---
 rtl/rv32im_alu_decode_stage_if.sv | 41 ++++
 rtl/rv32im_alu_decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_rv32im_alu_decode_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32im_alu_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the RV32IM decode stage.
// The slave modport is the decode stage; the master modport is its environment
// (fetch drives the instruction side, execute drives out_ready).
interface rv32im_alu_decode_stage_if;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_select;
  logic        op1_sel;
  logic        op2_sel;
  logic [31:0] imm;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3_out;
  logic        reg_write_en;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic        illegal;
  logic [31:0] pc_out;

  modport master (
    output instr_in, pc_in, in_valid, flush, out_ready,
    input  in_ready, out_valid, alu_select, op1_sel, op2_sel, imm,
           rs1_addr, rs2_addr, rd_addr, funct3_out, reg_write_en,
           mem_read, mem_write, branch, jump, illegal, pc_out
  );

  modport slave (
    input  instr_in, pc_in, in_valid, flush, out_ready,
    output in_ready, out_valid, alu_select, op1_sel, op2_sel, imm,
           rs1_addr, rs2_addr, rd_addr, funct3_out, reg_write_en,
           mem_read, mem_write, branch, jump, illegal, pc_out
  );
endinterface

// File: rtl/rv32im_alu_decode_stage.sv
// RV32IM decode stage: turns one instruction per accepted beat into the ALU
// select code, operand selects, immediate, register indices and class flags.
// One output register plus a one-entry skid keeps full throughput with a
// registered in_ready; flush and reset empty both entries.
module rv32im_alu_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  rv32im_alu_decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] SEL_ADD = 5'b00000;
  localparam logic [4:0] SEL_SUB = 5'b00010;
  localparam logic [4:0] SEL_SRA = 5'b10110;

  typedef struct packed {
    logic [4:0]      alu_select;
    logic            op1_sel;
    logic            op2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [2:0]      funct3;
    logic            reg_write_en;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } bundle_t;

  // M-extension codes: MULHSU and MULHU do not follow funct3 order.
  function automatic logic [4:0] mul_select(input logic [2:0] f3);
    case (f3)
      3'b000:  mul_select = 5'b00001;
      3'b001:  mul_select = 5'b00101;
      3'b010:  mul_select = 5'b01101;
      3'b011:  mul_select = 5'b01001;
      3'b100:  mul_select = 5'b10001;
      3'b101:  mul_select = 5'b10101;
      3'b110:  mul_select = 5'b11001;
      default: mul_select = 5'b11101;
    endcase
  endfunction

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign instr  = bus.instr_in;
  assign opcode = instr[6:0];
  assign f7     = instr[31:25];
  assign f3     = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'd0, instr[24:20]};

  // ---- stage 0: combinational decode of the offered instruction ----
  bundle_t dec_p0;
  logic    wr_p0;

  // Decode instruction class, ALU select and immediate; illegal kills all side effects.
  always_comb begin
    dec_p0          = '0;
    wr_p0           = 1'b0;
    dec_p0.rs1_addr = instr[19:15];
    dec_p0.rs2_addr = instr[24:20];
    dec_p0.rd_addr  = instr[11:7];
    dec_p0.funct3   = f3;
    dec_p0.pc       = bus.pc_in;
    case (opcode)
      OPC_OP: begin
        wr_p0 = 1'b1;
        if (f7 == 7'b0000000)
          dec_p0.alu_select = {f3, 2'b00};
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          dec_p0.alu_select = {f3, 2'b10};
        else if (f7 == 7'b0000001)
          dec_p0.alu_select = mul_select(f3);
        else
          dec_p0.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        wr_p0             = 1'b1;
        dec_p0.op2_sel    = 1'b1;
        dec_p0.alu_select = {f3, 2'b00};
        dec_p0.imm        = imm_i;
        // Shifts carry only shamt; the upper field selects logical vs arithmetic.
        if (f3 == 3'b001) begin
          dec_p0.imm = imm_sh;
          if (f7 != 7'b0000000) dec_p0.illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          dec_p0.imm = imm_sh;
          if (f7 == 7'b0100000)      dec_p0.alu_select = SEL_SRA;
          else if (f7 != 7'b0000000) dec_p0.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        wr_p0           = 1'b1;
        dec_p0.rs1_addr = 5'd0;
        dec_p0.op2_sel  = 1'b1;
        dec_p0.imm      = imm_u;
      end
      OPC_AUIPC: begin
        wr_p0          = 1'b1;
        dec_p0.op1_sel = 1'b1;
        dec_p0.op2_sel = 1'b1;
        dec_p0.imm     = imm_u;
      end
      OPC_JAL: begin
        wr_p0          = 1'b1;
        dec_p0.op1_sel = 1'b1;
        dec_p0.op2_sel = 1'b1;
        dec_p0.jump    = 1'b1;
        dec_p0.imm     = imm_j;
      end
      OPC_JALR: begin
        wr_p0          = 1'b1;
        dec_p0.op2_sel = 1'b1;
        dec_p0.jump    = 1'b1;
        dec_p0.imm     = imm_i;
      end
      OPC_LOAD: begin
        wr_p0           = 1'b1;
        dec_p0.op2_sel  = 1'b1;
        dec_p0.mem_read = 1'b1;
        dec_p0.imm      = imm_i;
      end
      OPC_STORE: begin
        dec_p0.op2_sel   = 1'b1;
        dec_p0.mem_write = 1'b1;
        dec_p0.imm       = imm_s;
      end
      OPC_BRANCH: begin
        dec_p0.alu_select = SEL_SUB;
        dec_p0.branch     = 1'b1;
        dec_p0.imm        = imm_b;
      end
      default: dec_p0.illegal = 1'b1;
    endcase
    if (dec_p0.illegal) begin
      dec_p0.alu_select = SEL_ADD;
      wr_p0             = 1'b0;
      dec_p0.mem_read   = 1'b0;
      dec_p0.mem_write  = 1'b0;
      dec_p0.branch     = 1'b0;
      dec_p0.jump       = 1'b0;
    end
    dec_p0.reg_write_en = wr_p0 & (dec_p0.rd_addr != 5'd0);
  end

  // ---- stage 1: output register and skid entry ----
  bundle_t out_p1;
  bundle_t skid_p1;
  logic    vld_p1;
  logic    skid_vld_p1;
  logic    out_load;
  logic    accept;

  assign bus.in_ready = SKID_EN ? ~skid_vld_p1 : (bus.out_ready | ~vld_p1);
  assign out_load     = ~vld_p1 | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // Output loads from skid first (order), else from decode; stalled accepts park in skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= '0;
      skid_p1     <= '0;
    end else if (bus.flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (out_load) begin
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept;
        if (accept) out_p1 <= dec_p0;
      end
    end else if (accept && SKID_EN) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign bus.out_valid    = vld_p1;
  assign bus.alu_select   = out_p1.alu_select;
  assign bus.op1_sel      = out_p1.op1_sel;
  assign bus.op2_sel      = out_p1.op2_sel;
  assign bus.imm          = out_p1.imm;
  assign bus.rs1_addr     = out_p1.rs1_addr;
  assign bus.rs2_addr     = out_p1.rs2_addr;
  assign bus.rd_addr      = out_p1.rd_addr;
  assign bus.funct3_out   = out_p1.funct3;
  assign bus.reg_write_en = out_p1.reg_write_en;
  assign bus.mem_read     = out_p1.mem_read;
  assign bus.mem_write    = out_p1.mem_write;
  assign bus.branch       = out_p1.branch;
  assign bus.jump         = out_p1.jump;
  assign bus.illegal      = out_p1.illegal;
  assign bus.pc_out       = out_p1.pc;

endmodule

// File: tb/tb_rv32im_alu_decode_stage.sv
// Bench for the RV32IM decode stage: directed decode cases, skid/stall ordering,
// flush, asynchronous reset mid-stall and a randomized backpressure run, with a
// scoreboard of expected bundles fed at accept and drained at each output transfer.
module tb_rv32im_alu_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32im_alu_decode_stage_if bus();

  rv32im_alu_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [4:0]  sel;
    logic        op1;
    logic        op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        we;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jmp;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_pop = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] pc_ctr;
  logic [6:0]  opcs [10];
  logic [6:0]  f7s [4];
  bit          rand_done;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] base_code(input logic [2:0] f3);
    return {f3, 2'b00};
  endfunction

  function automatic logic [4:0] mul_code(input logic [2:0] f3);
    return {f3[2], f3[1], f3[0] ^ (f3[1] & ~f3[2]), 2'b01};
  endfunction

  // Reference decode from the instruction-set definition.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic wr;
    e = '0; wr = 1'b0;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3; e.pc = pc;
    case (opc)
      7'h33: begin
        wr = 1'b1;
        if (f7 == 7'h00) e.sel = base_code(f3);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.sel = base_code(f3) + 5'd2;
        else if (f7 == 7'h01) e.sel = mul_code(f3);
        else e.ill = 1'b1;
      end
      7'h13: begin
        wr = 1'b1; e.op2 = 1'b1; e.sel = base_code(f3);
        e.imm = {{21{ins[31]}}, ins[30:20]};
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = 32'(ins[24:20]);
          if (f3 == 3'd5 && f7 == 7'h20) e.sel = e.sel + 5'd2;
          else if (f7 != 7'h00) e.ill = 1'b1;
        end
      end
      7'h37: begin wr = 1'b1; e.op2 = 1'b1; e.rs1 = 5'd0; e.imm = {ins[31:12], 12'h0}; end
      7'h17: begin wr = 1'b1; e.op1 = 1'b1; e.op2 = 1'b1; e.imm = {ins[31:12], 12'h0}; end
      7'h6f: begin
        wr = 1'b1; e.op1 = 1'b1; e.op2 = 1'b1; e.jmp = 1'b1;
        e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h67: begin wr = 1'b1; e.op2 = 1'b1; e.jmp = 1'b1; e.imm = {{21{ins[31]}}, ins[30:20]}; end
      7'h03: begin wr = 1'b1; e.op2 = 1'b1; e.mr = 1'b1; e.imm = {{21{ins[31]}}, ins[30:20]}; end
      7'h23: begin e.op2 = 1'b1; e.mw = 1'b1; e.imm = {{21{ins[31]}}, ins[30:25], ins[11:7]}; end
      7'h63: begin e.sel = 5'd2; e.br = 1'b1; e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.sel = 5'd0; wr = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jmp = 1'b0;
      e.imm = '0; e.op1 = 1'b0; e.op2 = 1'b0;
    end
    e.we = wr && (e.rd != 5'd0);
    return e;
  endfunction

  // Operand selects and immediate carry no meaning for an illegal bundle.
  function automatic exp_t observe();
    exp_t g;
    g.sel = bus.alu_select; g.op1 = bus.op1_sel; g.op2 = bus.op2_sel; g.imm = bus.imm;
    g.rs1 = bus.rs1_addr; g.rs2 = bus.rs2_addr; g.rd = bus.rd_addr; g.f3 = bus.funct3_out;
    g.we = bus.reg_write_en; g.mr = bus.mem_read; g.mw = bus.mem_write; g.br = bus.branch;
    g.jmp = bus.jump; g.ill = bus.illegal; g.pc = bus.pc_out;
    if (g.ill) begin g.imm = '0; g.op1 = 1'b0; g.op2 = 1'b0; end
    return g;
  endfunction

  // Scoreboard: pop on output transfer, push on accept, drop everything on flush/reset.
  always @(negedge clk) begin
    if (!rst_n) sb_q.delete();
    else begin
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        n_pop++;
        if (sb_q.size() == 0) chk("spurious_beat", 128'(bus.out_valid), 128'(0));
        else begin
          mon_e = sb_q.pop_front();
          chk("beat", 128'(observe()), 128'(mon_e));
        end
      end
      if (bus.flush) sb_q.delete();
      else if (bus.in_valid && bus.in_ready) sb_q.push_back(ref_dec(bus.instr_in, bus.pc_in));
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int k;
    bus.instr_in = ins; bus.pc_in = pc; bus.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk("send_timeout", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic dsend(input string tag, input logic [31:0] ins, input logic [4:0] sel,
                       input logic ill, input logic we);
    send(ins, pc_ctr);
    pc_ctr = pc_ctr + 32'd4;
    chk({tag, "_vld"}, 128'(bus.out_valid), 128'(1));
    chk({tag, "_sel"}, 128'(bus.alu_select), 128'(sel));
    chk({tag, "_ill"}, 128'(bus.illegal), 128'(ill));
    chk({tag, "_we"}, 128'(bus.reg_write_en), 128'(we));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = int'($urandom_range(0, 9));
    ins[6:0] = opcs[k];
    if (k < 2) ins[31:25] = f7s[$urandom_range(0, 3)];
    return ins;
  endfunction

  initial begin
    int p0;
    int k;
    opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h37; opcs[3] = 7'h17; opcs[4] = 7'h6f;
    opcs[5] = 7'h67; opcs[6] = 7'h03; opcs[7] = 7'h23; opcs[8] = 7'h63; opcs[9] = 7'h7f;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'h7f;
    rst_n = 1'b0; rand_done = 1'b0; pc_ctr = 32'h100;
    bus.in_valid = 1'b0; bus.instr_in = '0; bus.pc_in = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;

    repeat (3) @(posedge clk); #1;
    chk("reset_vld", 128'(bus.out_valid), 128'(0));
    chk("reset_sel", 128'(bus.alu_select), 128'(0));
    chk("reset_imm", 128'(bus.imm), 128'(0));
    chk("reset_pc", 128'(bus.pc_out), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_inrdy", 128'(bus.in_ready), 128'(1));

    // Directed decode cases
    dsend("add", 32'h002081B3, 5'b00000, 1'b0, 1'b1);
    chk("add_op2", 128'(bus.op2_sel), 128'(0));
    chk("add_rd", 128'(bus.rd_addr), 128'(3));
    dsend("sub", 32'h402081B3, 5'b00010, 1'b0, 1'b1);
    dsend("mulhu", 32'h027332B3, 5'b01001, 1'b0, 1'b1);
    dsend("srai", 32'h4030D113, 5'b10110, 1'b0, 1'b1);
    chk("srai_imm", 128'(bus.imm), 128'(3));
    dsend("addi_m1", 32'hFFF00093, 5'b00000, 1'b0, 1'b1);
    chk("addi_imm", 128'(bus.imm), 128'(32'hFFFFFFFF));
    chk("addi_op2", 128'(bus.op2_sel), 128'(1));
    dsend("addi_x0", 32'h00100013, 5'b00000, 1'b0, 1'b0);
    dsend("ill_opc", 32'h0000037F, 5'b00000, 1'b1, 1'b0);
    chk("ill_opc_mw", 128'(bus.mem_write), 128'(0));
    dsend("ill_f7", 32'h402091B3, 5'b00000, 1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("directed_drain", 128'(sb_q.size()), 128'(0));

    // Stall: A in output, B in skid, C held at the input
    bus.out_ready = 1'b0;
    send(32'h00500113, 32'h200);
    send(32'h00600193, 32'h204);
    chk("skid_inrdy", 128'(bus.in_ready), 128'(0));
    chk("skid_hold_pc", 128'(bus.pc_out), 128'(32'h200));
    bus.instr_in = 32'h00700213; bus.pc_in = 32'h208; bus.in_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("skid_held_pc", 128'(bus.pc_out), 128'(32'h200));
    chk("skid_held_rdy", 128'(bus.in_ready), 128'(0));
    p0 = n_pop;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("skid_pops", 128'(n_pop - p0), 128'(3));
    chk("skid_drain", 128'(sb_q.size()), 128'(0));
    chk("skid_idle", 128'(bus.out_valid), 128'(0));

    // Flush with output and skid full and a beat offered
    bus.out_ready = 1'b0;
    send(32'h00100293, 32'h300);
    send(32'h00200313, 32'h304);
    bus.instr_in = 32'h00300393; bus.pc_in = 32'h308; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_vld", 128'(bus.out_valid), 128'(0));
    chk("flush_inrdy", 128'(bus.in_ready), 128'(1));
    p0 = n_pop;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("flush_nobeat", 128'(n_pop - p0), 128'(0));

    // Asynchronous reset while stalled
    bus.out_ready = 1'b0;
    send(32'hFFF00093, 32'h400);
    send(32'h00100113, 32'h404);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", 128'(bus.out_valid), 128'(0));
    chk("rst_sel", 128'(bus.alu_select), 128'(0));
    chk("rst_imm", 128'(bus.imm), 128'(0));
    chk("rst_pc", 128'(bus.pc_out), 128'(0));
    chk("rst_we", 128'(bus.reg_write_en), 128'(0));
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_inrdy", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Random instructions under random backpressure
    pc_ctr = 32'h1000;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          send(rand_instr(), pc_ctr);
          pc_ctr = pc_ctr + 32'd4;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
    chk("random_drain", 128'(sb_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
